// File: rtl/alien_formation_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : alien_formation_mover_if
//  Description : Control/status bundle between the game FSM, the alien
//                formation mover and the sprite draw/erase logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alien_formation_mover_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           go;
    logic           pause;
    logic           kill;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           dir;
    logic           active;
    logic           landed;
    logic           hit;
    logic           drop_pulse;

    // Game FSM / sprite side: issues commands, observes position and status
    modport master (
        output go, pause, kill,
        input  x, y, dir, active, landed, hit, drop_pulse
    );

    // Mover side
    modport slave (
        input  go, pause, kill,
        output x, y, dir, active, landed, hit, drop_pulse
    );
endinterface
`default_nettype wire

// File: rtl/alien_formation_mover.sv
`default_nettype none
// ============================================================================
//  Module      : alien_formation_mover
//  Description : Sweeps one alien anchor between X_LEFT and X_RIGHT, dropping
//                one row at each edge and speeding up per drop, until the
//                landing row. Supports pause, kill/hit and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_formation_mover #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_LEFT      = 98,
    parameter int X_RIGHT     = 106,
    parameter int X_STEP      = 1,
    parameter int Y_START     = 15,
    parameter int Y_STEP      = 4,
    parameter int Y_LIMIT     = 112,
    parameter int TICK_DIV    = 833333,
    parameter int FRAMES_INIT = 15,
    parameter int FRAMES_MIN  = 2,
    parameter int SPEEDUP     = 1
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    alien_formation_mover_if.slave   bus
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RIGHT  = 3'd1;
    localparam logic [2:0] c_ST_DROP_L = 3'd2;
    localparam logic [2:0] c_ST_LEFT   = 3'd3;
    localparam logic [2:0] c_ST_DROP_R = 3'd4;
    localparam logic [2:0] c_ST_LANDED = 3'd5;
    localparam logic [2:0] c_ST_HIT    = 3'd6;

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_P_W    = (FRAMES_INIT > 1) ? $clog2(FRAMES_INIT + 1) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0]      c_X_LEFT    = X_W'(X_LEFT);
    localparam logic [X_W-1:0]      c_X_RIGHT   = X_W'(X_RIGHT);
    localparam logic [X_W-1:0]      c_X_STEP    = X_W'(X_STEP);
    localparam logic [X_W:0]        c_X_RIGHT_E = (X_W+1)'(X_RIGHT);
    localparam logic [X_W:0]        c_X_STEP_E  = (X_W+1)'(X_STEP);
    localparam logic [X_W:0]        c_X_LO_E    = (X_W+1)'(X_LEFT + X_STEP);
    localparam logic [Y_W-1:0]      c_Y_START   = Y_W'(Y_START);
    localparam logic [Y_W:0]        c_Y_STEP_E  = (Y_W+1)'(Y_STEP);
    localparam logic [Y_W:0]        c_Y_LIMIT_E = (Y_W+1)'(Y_LIMIT);
    localparam logic [c_P_W-1:0]    c_P_INIT    = c_P_W'(FRAMES_INIT);
    localparam logic [c_P_W-1:0]    c_P_MIN     = c_P_W'(FRAMES_MIN);
    localparam logic [31:0]         c_P_FLOOR32 = 32'(FRAMES_MIN + SPEEDUP);
    localparam logic [31:0]         c_SPEED32   = 32'(SPEEDUP);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [X_W-1:0]      r_x;
    logic [X_W-1:0]      w_x_nxt;
    logic [Y_W-1:0]      r_y;
    logic [Y_W-1:0]      w_y_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic [c_P_W-1:0]    r_period;
    logic [c_P_W-1:0]    w_period_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [c_P_W-1:0]    r_frame_cnt;
    logic [c_P_W-1:0]    w_frame_nxt;
    logic                r_drop_pulse;
    logic                w_drop_nxt;
    logic                w_active;
    logic                w_landed;
    logic                w_hit;

    // Arithmetic helpers, all widened by one bit so nothing wraps
    logic                w_tick;
    logic                w_frame_done;
    logic [X_W:0]        w_x_inc;
    logic [X_W-1:0]      w_x_right;
    logic [X_W-1:0]      w_x_left;
    logic [Y_W:0]        w_y_sum;
    logic [Y_W-1:0]      w_y_new;
    logic                w_land;
    logic [31:0]         w_per32;
    logic [c_P_W-1:0]    w_period_dec;

    assign w_tick       = (r_tick_cnt == c_TICK_LAST);
    assign w_frame_done = (r_frame_cnt >= (r_period - c_P_W'(1)));
    assign w_x_inc      = {1'b0, r_x} + c_X_STEP_E;
    assign w_x_right    = (w_x_inc > c_X_RIGHT_E) ? c_X_RIGHT : w_x_inc[X_W-1:0];
    assign w_x_left     = ({1'b0, r_x} < c_X_LO_E) ? c_X_LEFT : (r_x - c_X_STEP);
    assign w_y_sum      = {1'b0, r_y} + c_Y_STEP_E;
    assign w_y_new      = w_y_sum[Y_W] ? {Y_W{1'b1}} : w_y_sum[Y_W-1:0];
    assign w_land       = ({1'b0, w_y_new} >= c_Y_LIMIT_E);
    assign w_per32      = 32'(r_period);
    assign w_period_dec = (w_per32 >= c_P_FLOOR32) ? c_P_W'(w_per32 - c_SPEED32) : c_P_MIN;

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-next logic; kill outranks pause, pause outranks motion
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_dir_nxt    = r_dir;
        w_period_nxt = r_period;
        w_tick_nxt   = r_tick_cnt;
        w_frame_nxt  = r_frame_cnt;
        w_drop_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_LANDED, c_ST_HIT: begin
                if (bus.go) begin
                    w_state_nxt  = c_ST_RIGHT;
                    w_x_nxt      = c_X_LEFT;
                    w_y_nxt      = c_Y_START;
                    w_dir_nxt    = 1'b1;
                    w_period_nxt = c_P_INIT;
                    w_tick_nxt   = '0;
                    w_frame_nxt  = '0;
                end
            end
            c_ST_RIGHT, c_ST_LEFT: begin
                if (bus.kill) begin
                    w_state_nxt = c_ST_HIT;
                end else if (!bus.pause) begin
                    if (w_tick) begin
                        w_tick_nxt  = '0;
                        w_frame_nxt = w_frame_done ? '0 : (r_frame_cnt + c_P_W'(1));
                    end else begin
                        w_tick_nxt  = r_tick_cnt + c_TICK_W'(1);
                    end
                    if (w_tick && w_frame_done) begin
                        if (r_state == c_ST_RIGHT) begin
                            if (r_x == c_X_RIGHT) begin
                                w_state_nxt = c_ST_DROP_L;
                            end else begin
                                w_x_nxt = w_x_right;
                            end
                        end else begin
                            if (r_x == c_X_LEFT) begin
                                w_state_nxt = c_ST_DROP_R;
                            end else begin
                                w_x_nxt = w_x_left;
                            end
                        end
                    end
                end
            end
            c_ST_DROP_L, c_ST_DROP_R: begin
                if (bus.kill) begin
                    w_state_nxt = c_ST_HIT;
                end else if (!bus.pause) begin
                    w_y_nxt      = w_y_new;
                    w_drop_nxt   = 1'b1;
                    w_period_nxt = w_period_dec;
                    w_tick_nxt   = '0;
                    w_frame_nxt  = '0;
                    if (w_land) begin
                        w_state_nxt = c_ST_LANDED;
                    end else if (r_state == c_ST_DROP_L) begin
                        w_state_nxt = c_ST_LEFT;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = c_ST_RIGHT;
                        w_dir_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Position, direction, speed and timebase registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_x          <= c_X_LEFT;
            r_y          <= c_Y_START;
            r_dir        <= 1'b1;
            r_period     <= c_P_INIT;
            r_tick_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_dir        <= w_dir_nxt;
            r_period     <= w_period_nxt;
            r_tick_cnt   <= w_tick_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_drop_pulse <= w_drop_nxt;
        end
    end

    // Status decode straight from the registered state
    always_comb begin
        w_active = 1'b0;
        w_landed = 1'b0;
        w_hit    = 1'b0;
        case (r_state)
            c_ST_RIGHT, c_ST_LEFT, c_ST_DROP_L, c_ST_DROP_R: w_active = 1'b1;
            c_ST_LANDED:                                     w_landed = 1'b1;
            c_ST_HIT:                                        w_hit    = 1'b1;
            default:                                         w_active = 1'b0;
        endcase
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.dir        = r_dir;
    assign bus.active     = w_active;
    assign bus.landed     = w_landed;
    assign bus.hit        = w_hit;
    assign bus.drop_pulse = r_drop_pulse;

endmodule
`default_nettype wire

// File: doc/alien_formation_mover.md
Name: alien_formation_mover

Overview:
- Parametrised successor to the single-alien sweep controller.
- Moves one alien sprite anchor left/right between configurable bounds, dropping one row at each edge, until it reaches a landing row.
- Adds per-drop speed-up, pause, kill/hit handling, saturating steps, restart and status outputs.
- Sits between the game FSM (go/pause/kill) and the sprite draw/erase logic (x, y, drop_pulse).

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
X_LEFT, 98, left bound and start x
X_RIGHT, 106, right bound
X_STEP, 1, pixels per horizontal move
Y_START, 15, start y
Y_STEP, 4, pixels per drop
Y_LIMIT, 112, landing row: land when new y >= Y_LIMIT
TICK_DIV, 833333, clock cycles per tick (>=1)
FRAMES_INIT, 15, ticks per move at start (>=1)
FRAMES_MIN, 2, floor on ticks per move (>=1)
SPEEDUP, 1, ticks removed from period per drop

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous, active-high reset (1 = reset asserted)
go  in  1  start/restart; sampled only in IDLE, LANDED, HIT
pause  in  1  freezes counters and motion while 1
kill  in  1  alien hit; aborts movement
x  out  X_W  current x
y  out  Y_W  current y
dir  out  1  1 = moving right, 0 = left
active  out  1  1 in RIGHT, LEFT, DROP_L, DROP_R
landed  out  1  held 1 in LANDED
hit  out  1  held 1 in HIT
drop_pulse  out  1  one-cycle pulse on each drop cycle

Behaviour:
- Reset (async, any time, incl. mid-move): state IDLE, x=X_LEFT, y=Y_START, dir=1, period=FRAMES_INIT, tick_cnt=0, frame_cnt=0, active=landed=hit=drop_pulse=0.
- States: IDLE, RIGHT, DROP_L, LEFT, DROP_R, LANDED, HIT.
- Start: in IDLE/LANDED/HIT with go=1 -> next cycle RIGHT, x=X_LEFT, y=Y_START, dir=1, period=FRAMES_INIT, counters 0, landed=hit=0. go ignored in other states.
- Timebase (only in RIGHT/LEFT, pause=0): tick_cnt counts 0..TICK_DIV-1; tick when tick_cnt==TICK_DIV-1 (then wraps to 0). On tick: if frame_cnt >= period-1 then move strobe and frame_cnt=0, else frame_cnt+1. Counters clear on entry to RIGHT/LEFT.
- RIGHT, on strobe: if x==X_RIGHT -> DROP_L, x unchanged; else x <= min(x+X_STEP, X_RIGHT). Sum computed at X_W+1 bits.
- LEFT, on strobe: if x==X_LEFT -> DROP_R; else x <= max(x-X_STEP, X_LEFT). No underflow wrap.
- DROP_L/DROP_R: one cycle (unless paused). y <= y+Y_STEP (computed at Y_W+1 bits, saturate at all-ones). drop_pulse=1. period <= max(period-SPEEDUP, FRAMES_MIN), no wrap. Next: LANDED if new y >= Y_LIMIT, else LEFT (from DROP_L, dir=0) or RIGHT (from DROP_R, dir=1).
- LANDED/HIT: hold x, y until go.
- pause=1: state, x, y, counters, period frozen; a drop state is held and its drop_pulse is suppressed until pause falls.
- kill=1 in RIGHT/LEFT/DROP_*: next state HIT, x/y frozen, no drop applied that cycle. Priority: kill > pause > strobe/drop. kill in IDLE/LANDED/HIT is ignored.
- go and kill together in LANDED/HIT: go wins (restart).
- Outputs registered; x/y change the cycle after the strobe.

Test Plan:
Bench params: X_LEFT=10, X_RIGHT=14, X_STEP=2, Y_START=5, Y_STEP=4, Y_LIMIT=20, TICK_DIV=2, FRAMES_INIT=3, FRAMES_MIN=1, SPEEDUP=1.
- Reset then go -> strobes every 6 cycles: x 10->12->14; third strobe enters DROP_L -> y=9, drop_pulse exactly 1 cycle, dir=0, period=2 (strobes now every 4 cycles).
- Full run -> y 9,13,17, then 21: LANDED with landed=1, active=0, period floor 1 never below; go -> x=10, y=5, RIGHT, landed=0.
- X_STEP=3 variant -> x 10->13->14 (saturate), then drop; LEFT 14->11->10 (saturate at X_LEFT, no wrap).
- pause=1 for 20 cycles mid-RIGHT -> x, y, counters unchanged; pause during DROP_L -> y unchanged, no drop_pulse until release, then single drop.
- kill during LEFT at x=12 -> HIT next cycle, hit=1, active=0, x=12 held; kill+pause together -> HIT; go -> restart at x=10, y=5.
- resetn asserted asynchronously between clock edges mid-LEFT -> outputs to reset values immediately; go ignored while resetn=1.
